// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control FSM:
// opcodes, state encodings and datapath mux/ALU select codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC   = 4'd6;
    localparam logic [3:0] ST_ALUWB  = 4'd7;
    localparam logic [3:0] ST_BEQ    = 4'd8;
    localparam logic [3:0] ST_ADDIEX = 4'd9;
    localparam logic [3:0] ST_ADDIWB = 4'd10;
    localparam logic [3:0] ST_JUMP   = 4'd11;
    localparam logic [3:0] ST_BNE    = 4'd12;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_next_state.sv
// Combinational next-state logic for the multicycle MIPS control FSM.
// Wait states hold until mem_ready; unknown opcodes and encodings fall back to FETCH.
module mips_ctrl_next_state
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPW = 6,
    parameter int unsigned STW = 4
) (
    input  logic [STW-1:0] i_state,
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_mem_ready,
    output logic [STW-1:0] o_next_state
);

    always_comb begin
        o_next_state = STW'(ST_FETCH);
        case (i_state)
            STW'(ST_FETCH):  o_next_state = i_mem_ready ? STW'(ST_DECODE) : STW'(ST_FETCH);
            STW'(ST_DECODE): begin
                case (i_opcode)
                    OPW'(OP_LW), OPW'(OP_SW): o_next_state = STW'(ST_MEMADR);
                    OPW'(OP_RTYPE):           o_next_state = STW'(ST_EXEC);
                    OPW'(OP_BEQ):             o_next_state = STW'(ST_BEQ);
                    OPW'(OP_BNE):             o_next_state = STW'(ST_BNE);
                    OPW'(OP_ADDI):            o_next_state = STW'(ST_ADDIEX);
                    OPW'(OP_J):               o_next_state = STW'(ST_JUMP);
                    default:                  o_next_state = STW'(ST_FETCH);
                endcase
            end
            // IR is held, so the opcode still selects load vs store here.
            STW'(ST_MEMADR): o_next_state = (i_opcode == OPW'(OP_LW)) ? STW'(ST_MEMRD)
                                                                       : STW'(ST_MEMWR);
            STW'(ST_MEMRD):  o_next_state = i_mem_ready ? STW'(ST_MEMWB) : STW'(ST_MEMRD);
            STW'(ST_MEMWB):  o_next_state = STW'(ST_FETCH);
            STW'(ST_MEMWR):  o_next_state = i_mem_ready ? STW'(ST_FETCH) : STW'(ST_MEMWR);
            STW'(ST_EXEC):   o_next_state = STW'(ST_ALUWB);
            STW'(ST_ALUWB):  o_next_state = STW'(ST_FETCH);
            STW'(ST_BEQ):    o_next_state = STW'(ST_FETCH);
            STW'(ST_BNE):    o_next_state = STW'(ST_FETCH);
            STW'(ST_ADDIEX): o_next_state = STW'(ST_ADDIWB);
            STW'(ST_ADDIWB): o_next_state = STW'(ST_FETCH);
            STW'(ST_JUMP):   o_next_state = STW'(ST_FETCH);
            default:         o_next_state = STW'(ST_FETCH);
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: state register plus output decode.
// Outputs are Moore decodes of state; pc_load and ir_write also see zero/mem_ready.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPW = 6,
    parameter int unsigned STW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_load,
    output logic [1:0]     pc_src,
    output logic           iord,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [STW-1:0] state_dbg
);

    logic [STW-1:0] r_state;
    logic [STW-1:0] w_next_state;

    mips_ctrl_next_state #(
        .OPW (OPW),
        .STW (STW)
    ) u_next_state (
        .i_state      (r_state),
        .i_opcode     (opcode),
        .i_mem_ready  (mem_ready),
        .o_next_state (w_next_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STW'(ST_FETCH);
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        pc_load    = 1'b0;
        pc_src     = PCSRC_ALU;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        case (r_state)
            STW'(ST_FETCH): begin
                mem_rd    = 1'b1;
                alu_src_b = SRCB_FOUR;
                // PC+4 and IR load commit together on the memory-ready cycle.
                ir_write  = mem_ready;
                pc_load   = mem_ready;
            end
            STW'(ST_DECODE): begin
                alu_src_b = SRCB_IMM_SH;
            end
            STW'(ST_MEMADR): begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            STW'(ST_MEMRD): begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            STW'(ST_MEMWB): begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            STW'(ST_MEMWR): begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            STW'(ST_EXEC): begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            STW'(ST_ALUWB): begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            STW'(ST_BEQ), STW'(ST_BNE): begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_load   = (r_state == STW'(ST_BEQ)) ? zero : ~zero;
            end
            STW'(ST_ADDIEX): begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            STW'(ST_ADDIWB): begin
                reg_write = 1'b1;
            end
            STW'(ST_JUMP): begin
                pc_src  = PCSRC_JUMP;
                pc_load = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_dbg = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_load;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_load;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] state_dbg;

    outs_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    mips_multicycle_ctrl #(
        .OPW (6),
        .STW (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_load    (pc_load),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Expected outputs for a state, straight from the state table.
    function automatic outs_t model(input int st, input logic z, input logic mr);
        outs_t o;
        o    = '0;
        o.st = 4'(st);
        case (st)
            0:  begin o.mem_rd = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_load = mr; end
            1:  o.alu_src_b = 2'b11;
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  begin o.mem_rd = 1; o.iord = 1; end
            4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            5:  begin o.mem_wr = 1; o.iord = 1; end
            6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            7:  begin o.reg_write = 1; o.reg_dst = 1; end
            8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_load = z; end
            12: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_load = !z; end
            9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            10: o.reg_write = 1;
            11: begin o.pc_src = 2'b10; o.pc_load = 1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic step(input int st, input logic [5:0] op, input logic z, input logic mr,
                        input logic r);
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        rst       = r;
        sb_q.push_back(model(st, z, mr));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        outs_t act;
        outs_t exp;
        cyc++;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            act = '{state_dbg, pc_load, pc_src, iord, mem_rd, mem_wr, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outs cyc%0d state%0d: got %b required %b", cyc, exp.st, act,
                         exp);
            end
            if (mem_rd && mem_wr) begin
                errors++;
                $display("FAIL rd_wr_excl cyc%0d: got rd=1 wr=1 required not both", cyc);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        opcode    = 6'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // LW, no wait: 0,1,2,3,4
        step(0, LW, 0, 1, 0); step(1, LW, 0, 1, 0); step(2, LW, 0, 1, 0);
        step(3, LW, 0, 1, 0); step(4, LW, 0, 1, 0);
        // SW with three not-ready cycles in MEMWR
        step(0, SW, 0, 1, 0); step(1, SW, 0, 1, 0); step(2, SW, 0, 1, 0);
        step(5, SW, 0, 0, 0); step(5, SW, 0, 0, 0); step(5, SW, 0, 0, 0);
        step(5, SW, 0, 1, 0);
        // BEQ taken / not taken, BNE inverse
        step(0, BEQ, 0, 1, 0); step(1, BEQ, 0, 1, 0); step(8, BEQ, 1, 1, 0);
        step(0, BEQ, 0, 1, 0); step(1, BEQ, 0, 1, 0); step(8, BEQ, 0, 1, 0);
        step(0, BNE, 0, 1, 0); step(1, BNE, 0, 1, 0); step(12, BNE, 1, 1, 0);
        step(0, BNE, 0, 1, 0); step(1, BNE, 0, 1, 0); step(12, BNE, 0, 1, 0);
        // J and an illegal opcode acting as NOP
        step(0, J, 0, 1, 0); step(1, J, 0, 1, 0); step(11, J, 0, 1, 0);
        step(0, BAD, 0, 1, 0); step(1, BAD, 0, 1, 0);
        // RTYPE and ADDI, with a stalled fetch first
        step(0, RT, 0, 0, 0); step(0, RT, 0, 1, 0); step(1, RT, 0, 1, 0);
        step(6, RT, 0, 1, 0); step(7, RT, 0, 1, 0);
        step(0, ADDI, 0, 1, 0); step(1, ADDI, 0, 1, 0); step(9, ADDI, 0, 1, 0);
        step(10, ADDI, 0, 1, 0);
        // LW with a stalled MEMRD
        step(0, LW, 0, 1, 0); step(1, LW, 0, 1, 0); step(2, LW, 0, 1, 0);
        step(3, LW, 0, 0, 0); step(3, LW, 0, 1, 0); step(4, LW, 0, 1, 0);
        // Reset mid-write while memory is not ready
        step(0, SW, 0, 1, 0); step(1, SW, 0, 1, 0); step(2, SW, 0, 1, 0);
        step(5, SW, 0, 0, 1); step(0, SW, 0, 0, 0); step(0, J, 0, 1, 0);
        step(1, J, 0, 1, 0);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
